// File: rtl/fanout_buffer_tree.sv
`default_nettype none
// ============================================================================
// Module      : fanout_buffer_tree
// Description : Registered fanout stage. One valid/ready source stream is
//               broadcast to NUM_LOADS sinks. Each sink has its own FIFO of
//               DEPTH entries, so every sink drains at its own rate. The
//               source sees a single back-pressure signal that is decoded
//               from registered occupancy only.
// Ports       :
//   clk        - sole clock, rising edge
//   rst_n      - synchronous active-low reset
//   s_valid    - source word valid
//   s_ready    - block accepts a word this cycle
//   s_data     - source payload [WIDTH]
//   load_mask  - per-sink enable sampled on accept (FANOUT_MASK_EN only)
//   m_valid    - per-sink word available [NUM_LOADS]
//   m_ready    - per-sink consume [NUM_LOADS]
//   m_data     - per-sink payload, sink i at [i*WIDTH +: WIDTH]
//   busy       - any sink FIFO non-empty
// Options     : FANOUT_MASK_EN - adds load_mask; masked-off sinks are neither
//               written nor allowed to block acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module fanout_buffer_tree #(
  parameter int WIDTH     = 8,
  parameter int NUM_LOADS = 4,
  parameter int DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_data,
`ifdef FANOUT_MASK_EN
  input  logic [NUM_LOADS-1:0]       load_mask,
`endif
  output logic [NUM_LOADS-1:0]       m_valid,
  input  logic [NUM_LOADS-1:0]       m_ready,
  output logic [NUM_LOADS*WIDTH-1:0] m_data,
  output logic                       busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

  logic [NUM_LOADS-1:0] w_full;
  logic [NUM_LOADS-1:0] w_en;
  logic                 w_accept;

  // ready_q holds s_ready low through the reset cycle; it only rises on the
  // first edge with rst_n released, independent of FIFO occupancy.
  logic ready_q;
  logic ready_d;

  always_comb begin
    ready_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
    end
  end

`ifdef FANOUT_MASK_EN
  // Only sinks that would receive the word may block it. An all-zero mask
  // therefore always accepts and drops the word.
  assign w_en = load_mask;
`else
  assign w_en = {NUM_LOADS{1'b1}};
`endif

  // A full FIFO blocks even when it is being popped this cycle: s_ready is
  // decoded from registered counts, never from m_ready.
  assign s_ready  = ready_q && !(|(w_full & w_en));
  assign w_accept = s_valid && s_ready;
  assign busy     = |m_valid;

  for (genvar i = 0; i < NUM_LOADS; i++) begin : g_sink
    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [DEPTH-1:0][WIDTH-1:0] mem_d;
    logic [PTR_W-1:0]            wr_ptr_q;
    logic [PTR_W-1:0]            wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q;
    logic [PTR_W-1:0]            rd_ptr_d;
    logic [CNT_W-1:0]            count_q;
    logic [CNT_W-1:0]            count_d;
    logic                        w_push;
    logic                        w_pop;

    assign w_push = w_accept && w_en[i];
    assign w_pop  = m_valid[i] && m_ready[i];

    // Pointers are exactly PTR_W bits wide, so the increment wraps modulo
    // DEPTH for free (DEPTH is a power of two).
    always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (w_push) begin
        mem_d[wr_ptr_q] = s_data;
        wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
      end

      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      end

      case ({w_push, w_pop})
        2'b10:   count_d = count_q + C_CNT_ONE;
        2'b01:   count_d = count_q - C_CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // Storage is cleared too, so m_data never exposes pre-reset words.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        mem_q    <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        mem_q    <= mem_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    assign w_full[i]                   = (count_q == C_CNT_FULL);
    assign m_valid[i]                  = (count_q != '0);
    assign m_data[i*WIDTH +: WIDTH]    = mem_q[rd_ptr_q];
  end

endmodule
`default_nettype wire

// File: doc/fanout_buffer_tree.md
# fanout_buffer_tree

Parametrised, registered fanout stage that broadcasts one valid/ready source stream to NUM_LOADS independent sinks, each isolated by its own FIFO of DEPTH entries. It is the sequential successor to single-buffer fanout splitting: the block replaces a flat high-fanout net with per-load buffering. Each sink consumes at its own rate, and the source sees a single, registered back-pressure signal. It sits between a single driver domain and multiple hierarchical consumers in the same clock domain.

## Interface
- WIDTH, 8, payload width in bits (≥1)
- NUM_LOADS, 4, number of sink channels (2..16)
- DEPTH, 2, entries per sink FIFO; power of two, ≥2
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- s_valid  input  1  source word valid
- s_ready  output  1  block can accept a word this cycle
- s_data  input  WIDTH  source payload
- load_mask  input  NUM_LOADS  per-sink enable, sampled on accept (present only with FANOUT_MASK_EN)
- m_valid  output  NUM_LOADS  sink i has a word
- m_ready  input  NUM_LOADS  sink i consumes
- m_data  output  NUM_LOADS*WIDTH  sink i payload at bits [i*WIDTH +: WIDTH]
- busy  output  1  any sink FIFO non-empty

## Operation
- Accept: the block accepts a word when s_valid && s_ready. The word is written into every enabled sink FIFO in the same edge.
- s_ready = no enabled-capable FIFO is full, evaluated from registered occupancy only. There is no combinational path from m_ready or s_valid to s_ready.
- A full FIFO blocks acceptance even if that FIFO is popped in the same cycle. That word is accepted at the earliest on the following cycle.
- Pop: sink i pops when m_valid[i] && m_ready[i]. Sinks are fully independent; one stalled sink never stalls another until its own FIFO is full.
- Per FIFO: write pointer and read pointer are log2(DEPTH) bits, and both wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits, range 0..DEPTH.
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: count unchanged, both pointers advance.
- m_valid[i] = (count_i != 0). m_data slice i = storage at the read pointer. Order is strictly FIFO per sink.
- busy = OR of all m_valid.
- Reset (rst_n low at an edge):
  - All pointers and counts go to 0; m_valid = 0, busy = 0.
  - s_ready = 0 during the reset cycle and 1 on the first cycle after release.
  - m_data reads storage; storage is cleared to 0 on reset.
  - Reset mid-operation discards all buffered words, with no partial delivery.

## Timing
- Latency: a word accepted at edge N appears as m_valid[i]=1 in the cycle after edge N (1 cycle), when FIFO i was empty.
- Throughput: 1 word/cycle sustained while all sinks have m_ready=1.
- Back-pressure: s_ready falls in the cycle after the edge that fills any FIFO. It rises in the cycle after the edge that pops that FIFO.
- All outputs are registered or decoded from registered state. s_ready is not combinational on any input.

## Configuration
- FANOUT_MASK_EN defined:
  - The load_mask port exists. Only sinks with load_mask[i]=1 at accept receive the word.
  - s_ready considers only FIFOs whose mask bit is 1 in the current cycle. This is a combinational dependence on load_mask, which is permitted.
  - An accept with load_mask=0 is consumed and dropped, with no FIFO write.
- FANOUT_MASK_EN undefined:
  - No load_mask port. Every accept writes all NUM_LOADS FIFOs.
  - s_ready depends on all FIFOs.

## Test plan
- Reset and basic broadcast: hold rst_n=0 for 2 cycles, then release; send 0xA5 with all m_ready=1. Required: s_ready=1 after release, all m_valid=1 one cycle later, every slice =0xA5, busy then falls to 0.
- Independent stall: m_ready=4'b1110, DEPTH=2, stream 0x01,0x02,0x03. Required: s_ready=0 after two accepts. Sinks 1..3 receive 0x01,0x02 in order; raising m_ready[0] lets 0x03 be accepted next cycle.
- Full plus simultaneous pop: FIFO 0 full, m_ready[0]=1 and s_valid=1 in the same cycle. Required: no accept that cycle; accept on the following cycle; no word lost or duplicated.
- Pointer wrap: DEPTH=4, push/pop 10 words 0x10..0x19 with alternating m_ready stalls. Required: exact order on all sinks, counts never exceed 4.
- Reset mid-stream: 2 words buffered, assert rst_n=0 for 1 cycle. Required: m_valid=0 and busy=0 after the edge; old words are never delivered.
- Mask (FANOUT_MASK_EN): load_mask=4'b0101, send 0x3C. Required: only m_valid[0] and m_valid[2] are set. Then load_mask=0 with s_valid=1: accepted with no writes, busy unchanged.
